// File: rtl/friscv_pkg.sv
// Shared widths and state encodings for the instruction-memory loader.
package friscv_pkg;

  localparam int unsigned ARCH             = 32;
  localparam int unsigned IMEM_DEPTH_BYTES = 4096;
  localparam int unsigned IMEM_ADDR_WIDTH  = $clog2(IMEM_DEPTH_BYTES);
  localparam int unsigned IMEM_MAX_WORDS   = IMEM_DEPTH_BYTES / 4;

  // Loader frame-parsing states.
  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  // UART receiver bit-level states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/friscv_uart_rx.sv
// 8N1 UART receiver: synchronizes the line, validates the start bit at its
// centre, samples data LSB-first and strobes a byte or a framing error at
// mid-stop-bit.
module friscv_uart_rx
  import friscv_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);

  logic [1:0]     sync_q;
  logic           rx_s;
  logic           rx_prev_q;
  uart_rx_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     byte_q, byte_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;

  assign rx_s       = sync_q[1];
  assign rx_byte    = byte_q;
  assign byte_valid = valid_q;
  assign frame_err  = err_q;

  // Two-flop synchronizer plus previous-sample flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Bit timing, sampling and strobe generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF_BIT)) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = RX_DATA;
            bit_d   = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/friscv_imem_loader.sv
// Boot loader: receives a word-count-prefixed image over UART, writes it to
// instruction memory one word per cycle and releases the core when complete.
module friscv_imem_loader
  import friscv_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD_RATE   = 115200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       uart_rx_in,
  output logic                       imem_we_out,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_byte_out,
  output logic [ARCH-1:0]            imem_din_out,
  output logic                       core_rst_n_out,
  output logic                       load_done_out,
  output logic                       load_err_out
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  loader_state_t              state_q, state_d;
  logic [7:0]                 cnt_lo_q, cnt_lo_d;
  logic [15:0]                word_cnt_q, word_cnt_d;
  logic [15:0]                word_idx_q, word_idx_d;
  logic [1:0]                 byte_k_q, byte_k_d;
  logic [ARCH-1:0]            word_q, word_d;
  logic                       we_q, we_d;
  logic [IMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ARCH-1:0]            din_q, din_d;
  logic                       core_rst_n_q, core_rst_n_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic [15:0]                n_words_c;
  logic [ARCH-1:0]            word_c;

  friscv_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (uart_rx_in),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign imem_we_out        = we_q;
  assign imem_addr_byte_out = addr_q;
  assign imem_din_out       = din_q;
  assign core_rst_n_out     = core_rst_n_q;
  assign load_done_out      = done_q;
  assign load_err_out       = err_q;

  // Loader state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_lo_q     <= '0;
      word_cnt_q   <= '0;
      word_idx_q   <= '0;
      byte_k_q     <= '0;
      word_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_lo_q     <= cnt_lo_d;
      word_cnt_q   <= word_cnt_d;
      word_idx_q   <= word_idx_d;
      byte_k_q     <= byte_k_d;
      word_q       <= word_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Frame parser: count bytes, word assembly, memory write sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    word_cnt_d = word_cnt_q;
    word_idx_d = word_idx_q;
    byte_k_d   = byte_k_q;
    word_d     = word_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    n_words_c  = {rx_byte, cnt_lo_q};
    word_c     = word_q;
    word_c[{byte_k_q, 3'b000} +: 8] = rx_byte;

    case (state_q)
      IDLE: begin
        if (frame_err) begin
          state_d = ERR;
        end else if (byte_valid) begin
          cnt_lo_d = rx_byte;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (frame_err) begin
          state_d = ERR;
        end else if (byte_valid) begin
          word_cnt_d = n_words_c;
          word_idx_d = '0;
          byte_k_d   = '0;
          if (n_words_c == 16'd0) begin
            state_d = DONE;
          end else if (32'(n_words_c) > IMEM_MAX_WORDS) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (frame_err) begin
          state_d = ERR;
        end else if (byte_valid) begin
          word_d   = word_c;
          byte_k_d = byte_k_q + 2'd1;
          if (byte_k_q == 2'd3) begin
            state_d = WRITE;
            we_d    = 1'b1;
            addr_d  = IMEM_ADDR_WIDTH'({word_idx_q, 2'b00});
            din_d   = word_c;
          end
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        if (frame_err) begin
          state_d = ERR;
        end else if (word_idx_q == word_cnt_q - 16'd1) begin
          state_d = DONE;
        end else begin
          state_d = DATA;
        end
      end
      DONE: begin
        // Any good byte starts a reload; framing noise is ignored here.
        if (byte_valid) begin
          cnt_lo_d   = rx_byte;
          word_idx_d = '0;
          state_d    = CNT_HI;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: state_d = IDLE;
    endcase

    core_rst_n_d = (state_d == DONE);
    done_d       = (state_d == DONE);
    err_d        = (state_d == ERR);
  end

endmodule

// File: tb/tb_friscv_imem_loader.sv
// Self-checking bench for the UART instruction-memory loader.
module tb_friscv_imem_loader;
  import friscv_pkg::*;

  localparam int unsigned CPB = 100;

  typedef struct packed {
    logic [IMEM_ADDR_WIDTH-1:0] addr;
    logic [ARCH-1:0]            data;
  } wr_t;
  typedef logic [7:0] bq_t[$];
  typedef wr_t wq_t[$];

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       uart_rx_in = 1'b1;
  logic                       imem_we_out;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr_byte_out;
  logic [ARCH-1:0]            imem_din_out;
  logic                       core_rst_n_out;
  logic                       load_done_out;
  logic                       load_err_out;

  int  n_checks = 0;
  int  n_pass   = 0;
  wq_t wr_log;
  int  dbl_we   = 0;
  logic we_prev = 1'b0;

  friscv_imem_loader #(
    .CLK_FREQ_HZ (100000000),
    .BAUD_RATE   (1000000)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .uart_rx_in         (uart_rx_in),
    .imem_we_out        (imem_we_out),
    .imem_addr_byte_out (imem_addr_byte_out),
    .imem_din_out       (imem_din_out),
    .core_rst_n_out     (core_rst_n_out),
    .load_done_out      (load_done_out),
    .load_err_out       (load_err_out)
  );

  always #5 clk = ~clk;

  // Record every memory write and any write strobe longer than one cycle.
  always @(negedge clk) begin
    if (imem_we_out) wr_log.push_back(wr_t'{addr: imem_addr_byte_out, data: imem_din_out});
    if (imem_we_out && we_prev) dbl_we++;
    we_prev = imem_we_out;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    uart_rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      tick(CPB);
    end
    uart_rx_in = stop_bit;
    tick(CPB);
    uart_rx_in = 1'b1;
    tick(5);
  endtask

  task automatic send_frame(input bq_t bytes);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    wr_log.delete();
    dbl_we = 0;
  endtask

  // Reference: interpret a host frame from scratch.
  task automatic model_frame(input bq_t bytes, output wq_t exp, output bit exp_done,
                             output bit exp_err);
    int unsigned n, v;
    exp.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (bytes.size() < 2) return;
    n = int'(bytes[0]) + 256 * int'(bytes[1]);
    if (n > IMEM_DEPTH_BYTES / 4) begin
      exp_err = 1'b1;
      return;
    end
    for (int unsigned w = 0; w < n; w++) begin
      if (2 + 4 * w + 3 >= bytes.size()) return;
      v = int'(bytes[2+4*w]) + 256 * int'(bytes[3+4*w]) +
          65536 * int'(bytes[4+4*w]) + 16777216 * int'(bytes[5+4*w]);
      exp.push_back(wr_t'{addr: IMEM_ADDR_WIDTH'(4 * w), data: v});
    end
    exp_done = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    n_checks++; if (imem_we_out !== 1'b0) $display("FAIL reset_we: got %b want 0", imem_we_out); else n_pass++;
    n_checks++; if (imem_addr_byte_out !== '0) $display("FAIL reset_addr: got %h want 0", imem_addr_byte_out); else n_pass++;
    n_checks++; if (imem_din_out !== '0) $display("FAIL reset_din: got %h want 0", imem_din_out); else n_pass++;
    n_checks++; if (core_rst_n_out !== 1'b0) $display("FAIL reset_core: got %b want 0", core_rst_n_out); else n_pass++;
    n_checks++; if (load_done_out !== 1'b0) $display("FAIL reset_done: got %b want 0", load_done_out); else n_pass++;
    n_checks++; if (load_err_out !== 1'b0) $display("FAIL reset_err: got %b want 0", load_err_out); else n_pass++;
  endtask

  task automatic test_basic();
    bq_t b = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    wq_t exp; bit ed, ee;
    pulse_reset();
    model_frame(b, exp, ed, ee);
    for (int i = 0; i < 3; i++) send_byte(b[i]);
    n_checks++; if (core_rst_n_out !== 1'b0) $display("FAIL basic_core_held: got %b want 0", core_rst_n_out); else n_pass++;
    for (int i = 3; i < b.size(); i++) send_byte(b[i]);
    tick(10);
    n_checks++; if (wr_log.size() !== exp.size()) $display("FAIL basic_nwr: got %0d want %0d", wr_log.size(), exp.size()); else n_pass++;
    for (int i = 0; i < exp.size() && i < wr_log.size(); i++) begin
      n_checks++; if (wr_log[i] !== exp[i]) $display("FAIL basic_wr%0d: got %h want %h", i, wr_log[i], exp[i]); else n_pass++;
    end
    n_checks++; if (load_done_out !== ed) $display("FAIL basic_done: got %b want %b", load_done_out, ed); else n_pass++;
    n_checks++; if (core_rst_n_out !== 1'b1) $display("FAIL basic_core: got %b want 1", core_rst_n_out); else n_pass++;
    n_checks++; if (load_err_out !== ee) $display("FAIL basic_err: got %b want %b", load_err_out, ee); else n_pass++;
    n_checks++; if (dbl_we !== 0) $display("FAIL basic_we_width: got %0d long strobes want 0", dbl_we); else n_pass++;
    n_checks++; if (imem_addr_byte_out !== 12'h004) $display("FAIL basic_addr_hold: got %h want 004", imem_addr_byte_out); else n_pass++;
    n_checks++; if (imem_din_out !== 32'h00A00113) $display("FAIL basic_din_hold: got %h want 00a00113", imem_din_out); else n_pass++;
  endtask

  task automatic test_reload();
    bq_t b = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wq_t exp; bit ed, ee;
    model_frame(b, exp, ed, ee);
    wr_log.delete();
    send_byte(b[0]);
    n_checks++; if (core_rst_n_out !== 1'b0) $display("FAIL reload_core_drop: got %b want 0", core_rst_n_out); else n_pass++;
    n_checks++; if (load_done_out !== 1'b0) $display("FAIL reload_done_clr: got %b want 0", load_done_out); else n_pass++;
    for (int i = 1; i < b.size(); i++) send_byte(b[i]);
    tick(10);
    n_checks++; if (wr_log.size() !== exp.size()) $display("FAIL reload_nwr: got %0d want %0d", wr_log.size(), exp.size()); else n_pass++;
    for (int i = 0; i < exp.size() && i < wr_log.size(); i++) begin
      n_checks++; if (wr_log[i] !== exp[i]) $display("FAIL reload_wr%0d: got %h want %h", i, wr_log[i], exp[i]); else n_pass++;
    end
    n_checks++; if (load_done_out !== ed) $display("FAIL reload_done: got %b want %b", load_done_out, ed); else n_pass++;
    n_checks++; if (core_rst_n_out !== 1'b1) $display("FAIL reload_core: got %b want 1", core_rst_n_out); else n_pass++;
  endtask

  task automatic test_zero();
    pulse_reset();
    send_frame('{8'h00, 8'h00});
    n_checks++; if (load_done_out !== 1'b1) $display("FAIL zero_done: got %b want 1", load_done_out); else n_pass++;
    n_checks++; if (core_rst_n_out !== 1'b1) $display("FAIL zero_core: got %b want 1", core_rst_n_out); else n_pass++;
    n_checks++; if (wr_log.size() !== 0) $display("FAIL zero_nwr: got %0d want 0", wr_log.size()); else n_pass++;
    send_byte(8'h55, 1'b0);
    tick(10);
    n_checks++; if (load_done_out !== 1'b1) $display("FAIL done_ferr_ignored: got %b want 1", load_done_out); else n_pass++;
    n_checks++; if (load_err_out !== 1'b0) $display("FAIL done_ferr_err: got %b want 0", load_err_out); else n_pass++;
  endtask

  task automatic test_glitch();
    bq_t b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    wq_t exp; bit ed, ee;
    pulse_reset();
    uart_rx_in = 1'b0;
    tick(40);
    uart_rx_in = 1'b1;
    tick(200);
    n_checks++; if (load_err_out !== 1'b0) $display("FAIL glitch_err: got %b want 0", load_err_out); else n_pass++;
    n_checks++; if (load_done_out !== 1'b0) $display("FAIL glitch_done: got %b want 0", load_done_out); else n_pass++;
    for (int i = 2; i < 6; i++) b[i] = 8'($urandom);
    model_frame(b, exp, ed, ee);
    send_frame(b);
    tick(10);
    n_checks++; if (wr_log.size() !== exp.size()) $display("FAIL glitch_nwr: got %0d want %0d", wr_log.size(), exp.size()); else n_pass++;
    for (int i = 0; i < exp.size() && i < wr_log.size(); i++) begin
      n_checks++; if (wr_log[i] !== exp[i]) $display("FAIL glitch_wr%0d: got %h want %h", i, wr_log[i], exp[i]); else n_pass++;
    end
    n_checks++; if (load_done_out !== ed) $display("FAIL glitch_done_after: got %b want %b", load_done_out, ed); else n_pass++;
  endtask

  task automatic test_framing();
    pulse_reset();
    send_frame('{8'h02, 8'h00, 8'h11, 8'h22});
    send_byte(8'h33, 1'b0);
    tick(10);
    n_checks++; if (load_err_out !== 1'b1) $display("FAIL frame_err: got %b want 1", load_err_out); else n_pass++;
    send_frame('{8'h44, 8'h55});
    n_checks++; if (load_err_out !== 1'b1) $display("FAIL frame_err_sticky: got %b want 1", load_err_out); else n_pass++;
    n_checks++; if (core_rst_n_out !== 1'b0) $display("FAIL frame_core: got %b want 0", core_rst_n_out); else n_pass++;
    n_checks++; if (wr_log.size() !== 0) $display("FAIL frame_nwr: got %0d want 0", wr_log.size()); else n_pass++;
  endtask

  task automatic test_overflow();
    int unsigned nb = IMEM_DEPTH_BYTES / 4 + 1;
    bq_t b;
    wq_t exp; bit ed, ee;
    b = '{8'(nb), 8'(nb >> 8), 8'h12, 8'h34, 8'h56, 8'h78};
    model_frame(b, exp, ed, ee);
    pulse_reset();
    send_frame(b);
    tick(10);
    n_checks++; if (load_err_out !== ee) $display("FAIL ovf_err: got %b want %b", load_err_out, ee); else n_pass++;
    n_checks++; if (wr_log.size() !== exp.size()) $display("FAIL ovf_nwr: got %0d want %0d", wr_log.size(), exp.size()); else n_pass++;
    n_checks++; if (core_rst_n_out !== 1'b0) $display("FAIL ovf_core: got %b want 0", core_rst_n_out); else n_pass++;
    n_checks++; if (load_done_out !== 1'b0) $display("FAIL ovf_done: got %b want 0", load_done_out); else n_pass++;
    pulse_reset();
    n_checks++; if (load_err_out !== 1'b0) $display("FAIL ovf_err_cleared: got %b want 0", load_err_out); else n_pass++;
  endtask

  task automatic test_rst_mid();
    bq_t b = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    wq_t exp; bit ed, ee;
    model_frame(b, exp, ed, ee);
    pulse_reset();
    for (int i = 0; i < 5; i++) send_byte(b[i]);
    pulse_reset();
    n_checks++; if (load_done_out !== 1'b0 || load_err_out !== 1'b0) $display("FAIL rstmid_flags: got done=%b err=%b want 0 0", load_done_out, load_err_out); else n_pass++;
    send_frame(b);
    tick(10);
    n_checks++; if (wr_log.size() !== exp.size()) $display("FAIL rstmid_nwr: got %0d want %0d", wr_log.size(), exp.size()); else n_pass++;
    for (int i = 0; i < exp.size() && i < wr_log.size(); i++) begin
      n_checks++; if (wr_log[i] !== exp[i]) $display("FAIL rstmid_wr%0d: got %h want %h", i, wr_log[i], exp[i]); else n_pass++;
    end
    n_checks++; if (core_rst_n_out !== 1'b1) $display("FAIL rstmid_core: got %b want 1", core_rst_n_out); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 2; it++) begin
      int unsigned n = $urandom_range(1, 2);
      bq_t b;
      wq_t exp; bit ed, ee;
      b.push_back(8'(n));
      b.push_back(8'h00);
      for (int unsigned k = 0; k < 4 * n; k++) b.push_back(8'($urandom));
      model_frame(b, exp, ed, ee);
      pulse_reset();
      send_frame(b);
      tick(10);
      n_checks++; if (wr_log.size() !== exp.size()) $display("FAIL rand%0d_nwr: got %0d want %0d", it, wr_log.size(), exp.size()); else n_pass++;
      for (int i = 0; i < exp.size() && i < wr_log.size(); i++) begin
        n_checks++; if (wr_log[i] !== exp[i]) $display("FAIL rand%0d_wr%0d: got %h want %h", it, i, wr_log[i], exp[i]); else n_pass++;
      end
      n_checks++; if (load_done_out !== ed) $display("FAIL rand%0d_done: got %b want %b", it, load_done_out, ed); else n_pass++;
      n_checks++; if (dbl_we !== 0) $display("FAIL rand%0d_we_width: got %0d want 0", it, dbl_we); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_zero();
    test_glitch();
    test_framing();
    test_overflow();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/friscv_imem_loader.md
FRISCV_IMEM_LOADER -- requirements
Module: friscv_imem_loader

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, UART bit rate.
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port uart_rx_in  input  1  asynchronous serial line, 8N1, idle high.
REQ-006 SHALL have port imem_we_out  output  1  instruction-memory port-A write enable.
REQ-007 SHALL have port imem_addr_byte_out  output  IMEM_ADDR_WIDTH  port-A byte address.
REQ-008 SHALL have port imem_din_out  output  ARCH  port-A write data word.
REQ-009 SHALL have port core_rst_n_out  output  1  active-low reset driven to the core; 0 = core held.
REQ-010 SHALL have port load_done_out  output  1  image fully written.
REQ-011 SHALL have port load_err_out  output  1  sticky load error.

Function
REQ-012 SHALL pass uart_rx_in through a 2-flop synchronizer before any use.
REQ-013 SHALL use CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer division) for bit timing.
REQ-014 SHALL detect a start bit on a 1->0 edge, re-check it low at CLKS_PER_BIT/2, and abort to idle if high (glitch).
REQ-015 SHALL sample 8 data bits LSB-first at bit centres, then the stop bit; stop=0 is a framing error.
REQ-016 SHALL produce a 1-cycle byte-valid strobe per good byte, no earlier than mid-stop-bit.
REQ-017 SHALL accept host frame: word count N (16-bit, little-endian, 2 bytes), then N words, each 4 bytes little-endian.
REQ-018 SHALL implement FSM states IDLE, CNT_HI, DATA, WRITE, DONE, ERR.
REQ-019 IDLE: first byte = N[7:0] -> CNT_HI; second byte = N[15:8] -> DATA, or DONE if N==0, or ERR if N > IMEM_DEPTH_BYTES/4.
REQ-020 DATA: assemble 4 bytes, byte k into bits [8k+7:8k]; after 4th byte -> WRITE.
REQ-021 WRITE: imem_we_out=1 for exactly one cycle, address = 4*word_index, data = assembled word; increment word_index; -> DONE if word_index was N-1, else DATA.
REQ-022 Word addresses SHALL never wrap; enforced by REQ-019 bound check.
REQ-023 core_rst_n_out SHALL be 0 in IDLE, CNT_HI, DATA, WRITE and ERR; 1 only in DONE.
REQ-024 DONE: load_done_out=1; a new good byte SHALL restart as IDLE's first byte (reload): clear load_done_out, reassert core reset in the same cycle, word_index=0.
REQ-025 Framing error in any state other than DONE SHALL go to ERR; in DONE it SHALL be ignored.
REQ-026 ERR: load_err_out=1, no writes, core held; exit only via rst.
REQ-027 imem_addr_byte_out/imem_din_out SHALL hold the last written value when imem_we_out=0.

Reset
REQ-028 On rst: FSM=IDLE, imem_we_out=0, imem_addr_byte_out=0, imem_din_out=0, core_rst_n_out=0, load_done_out=0, load_err_out=0, word_index=0, synchronizer flops=1, UART RX idle.
REQ-029 rst mid-byte or mid-image SHALL discard partial data; the host re-sends the entire frame.

Structure
REQ-030 ARCH, IMEM_ADDR_WIDTH, IMEM_DEPTH_BYTES SHALL come from friscv_pkg; the loader FSM state enum SHALL be added there as loader_state_t.
REQ-031 UART receive (REQ-012..016) SHALL be sub-module friscv_uart_rx with outputs byte, byte-valid, frame-error.

Verification (CLK_FREQ_HZ=100000000, BAUD_RATE=1000000 -> CLKS_PER_BIT=100)
REQ-032 Bytes 02 00 93 00 50 00 13 01 A0 00 -> writes 0x00500093 @0x000 and 0x00A00113 @0x004, one cycle each; then core_rst_n_out=1, load_done_out=1.
REQ-033 Bytes 00 00 -> no writes; DONE directly after 2nd byte's stop bit.
REQ-034 N = IMEM_DEPTH_BYTES/4 + 1 -> ERR, load_err_out=1, no writes, core_rst_n_out stays 0 until rst.
REQ-035 40-cycle low glitch on idle line -> no byte strobe, FSM stays IDLE; byte with stop bit 0 mid-DATA -> ERR.
REQ-036 rst pulse after 3rd data byte, then full resend of REQ-032 frame -> only the two correct writes occur.
REQ-037 After REQ-032 completes, resend 01 00 EF BE AD DE -> core_rst_n_out drops at 1st byte, write 0xDEADBEEF @0x000, DONE again.
